cms_stream_arbiter: RTL and testbench
=====================================

# cms_stream_arbiter

Round-robin, packet-locked arbiter that merges the AXI-Stream trace outputs of up to 8 continuous-monitoring instances (one per monitored core) onto one DMA FIFO stream. Each source keeps the grant until it sends a `tlast` beat or reaches a programmable burst limit. Every output beat is tagged with its source index. The block sits between the per-core monitors and the single AXI DMA S2MM port.

## Interface
- `NUM_SOURCES`, default 2: number of upstream monitors; legal range 2..8.
- `DATA_WIDTH`, default `AXI_DATA_WIDTH`: beat width, equal to the monitor packet width.
- `SRC_ID_WIDTH`, default `$clog2(NUM_SOURCES)`: width of the source tag.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `s_axis_tvalid`  in  NUM_SOURCES  per-source valid.
- `s_axis_tready`  out  NUM_SOURCES  per-source ready.
- `s_axis_tdata`  in  NUM_SOURCES x DATA_WIDTH  per-source data; unpacked array indexed by source.
- `s_axis_tlast`  in  NUM_SOURCES  per-source last.
- `m_axis_tvalid`  out  1  merged valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tdata`  out  DATA_WIDTH  merged data.
- `m_axis_tlast`  out  1  registered copy of the granted source's `tlast`.
- `m_axis_tid`  out  SRC_ID_WIDTH  index of the source that produced the beat.
- `src_enable`  in  NUM_SOURCES  a source whose bit is 0 is never newly granted.
- `burst_limit`  in  16  maximum beats per grant; 0 means unlimited (release only on `tlast`).
- `active_src`  out  SRC_ID_WIDTH  current or last grant index.
- `locked`  out  1  high while in ARB_LOCKED.
- `switch_count`  out  32  number of grants issued; wraps at 2^32.

## Operation
- Two-state FSM with states ARB_IDLE and ARB_LOCKED.
- **ARB_IDLE:**
  - Candidates are sources with `s_axis_tvalid[i] & src_enable[i]`.
  - The picker searches from `(last_grant+1) mod NUM_SOURCES` upward, wrapping.
  - On a hit, the next state is ARB_LOCKED with `grant` set to the hit index.
  - On the same edge: `beat_cnt` is cleared, `burst_limit` is sampled into `limit_q`, `switch_count` increments, and `last_grant` is set to the hit index.
  - With no candidate, the FSM stays in ARB_IDLE.
- **ARB_LOCKED:**
  - `s_axis_tready[grant] = ~m_axis_tvalid | m_axis_tready`. All other readies are 0.
  - A beat is accepted when `s_axis_tvalid[grant] & s_axis_tready[grant]`.
  - On each accepted beat, `beat_cnt` increments.
  - Release to ARB_IDLE when the accepted beat has `tlast`, or when `limit_q != 0` and `beat_cnt+1 == limit_q`.
- **Output register:**
  - On an accepted beat, `m_axis_tdata`, `m_axis_tlast` and `m_axis_tid` load from the granted source, and `m_axis_tvalid` becomes 1.
  - Otherwise, if `m_axis_tready` is high, `m_axis_tvalid` becomes 0.
  - Data must not change while `m_axis_tvalid & ~m_axis_tready`.
- **Boundary conditions:**
  - Deasserting `src_enable[grant]` mid-burst does not abort the burst. It only blocks re-grant.
  - A granted source that drops `tvalid` mid-burst holds the lock, and the FSM waits indefinitely.
  - Changing `burst_limit` mid-burst has no effect until the next grant.
  - When the burst limit forces a release without `tlast`, the output `tlast` stays as the source drove it (0).
  - When several sources are valid, each is granted exactly once per rotation.
- **Reset values** (all asserted asynchronously):
  - `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `m_axis_tid`, `s_axis_tready`, `locked`, `switch_count`: 0.
  - `active_src`: 0.
  - `last_grant`: `NUM_SOURCES-1`, so source 0 wins first.
  - FSM: ARB_IDLE.
  - Any beat in the output register is discarded.

## Timing
- Arbitration costs 1 cycle: a valid source in IDLE at edge N is locked after edge N, and its first beat can be accepted at edge N+1.
- Source-to-output latency is 1 cycle; the output register is loaded on the accepting edge.
- Throughput is 1 beat/cycle within a grant while `m_axis_tready` is held high.
- Each grant switch costs 1 bubble cycle (an IDLE visit), including re-granting the same source.
- `s_axis_tready` depends combinationally on `m_axis_tready`, the state and `grant`. It has no dependency on any `s_axis_tvalid`.
- `locked` and `active_src` are registered and reflect the state after each edge.

## Structure
- Shared package `continuous_monitoring_system_pkg` gains:
  - `typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t`;
  - `CMS_ARB_MAX_SOURCES = 8`;
  - `CMS_ARB_BURST_LIMIT_WIDTH = 16`.
- One combinational sub-module, `round_robin_picker`:
  - parameter `N`;
  - inputs `request[N]` and `last[$clog2(N)]`;
  - outputs `found` and `index`.

## Test plan
- **Round-robin alternation:** N=2, both sources continuously valid, 4-beat packets with `tlast` on the 4th beat, `burst_limit=0`, `m_axis_tready=1` → `m_axis_tid` sequence 0,0,0,0,1,1,1,1,0,…; one bubble between packets; `switch_count` increments per packet.
- **Burst limit:** N=2, `burst_limit=3`, source 0 sends a 10-beat packet, source 1 idle → groups of 3 beats, each separated by one bubble; source 0 is re-granted each time; output `tlast` appears only on beat 10.
- **Downstream backpressure:** `m_axis_tready` toggles 1,0,0,1 → `m_axis_tdata` is stable while stalled; no beat is lost or duplicated (scoreboard of 64 beats).
- **Enable mask:** `src_enable=2'b10` with both sources valid → only tid=1 beats appear. Clearing bit 1 mid-packet → the packet completes, then no further grant occurs.
- **Reset mid-burst:** assert `rst_n` low during beat 2 of a packet → outputs are 0 asynchronously. After release, source 0 is granted first and the next accepted beat is the source's current head.

Source files
------------

// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types and constants for the continuous-monitoring system blocks.
package continuous_monitoring_system_pkg;

   localparam int AXI_DATA_WIDTH            = 32;
   localparam int CMS_ARB_MAX_SOURCES       = 8;
   localparam int CMS_ARB_BURST_LIMIT_WIDTH = 16;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

endpackage

// File: rtl/cms_stream_arbiter_picker.sv
// Combinational round-robin picker: first requester at or after last+1, wrapping.
module round_robin_picker #(
   parameter  int N  = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  request,
   input  logic [IW-1:0] last,
   output logic          found,
   output logic [IW-1:0] index
);

   logic [IW-1:0] cand;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      found = 1'b0;
      index = '0;
      cand  = '0;
      // Walk from the farthest position back to the nearest so the nearest hit wins.
      for (int k = N; k >= 1; k--) begin
         cand = IW'((int'(last) + k) % N);
         if (request[cand]) begin
            found = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/cms_stream_arbiter.sv
// Round-robin, packet-locked merge of per-core monitor trace streams onto one
// AXI-Stream DMA port; every output beat carries its source index in m_axis_tid.
module cms_stream_arbiter
   import continuous_monitoring_system_pkg::*;
#(
   parameter int NUM_SOURCES  = 2,
   parameter int DATA_WIDTH   = AXI_DATA_WIDTH,
   parameter int SRC_ID_WIDTH = $clog2(NUM_SOURCES)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_SOURCES-1:0]               s_axis_tvalid,
   output logic [NUM_SOURCES-1:0]               s_axis_tready,
   input  logic [DATA_WIDTH-1:0]                s_axis_tdata [NUM_SOURCES],
   input  logic [NUM_SOURCES-1:0]               s_axis_tlast,
   output logic                                 m_axis_tvalid,
   input  logic                                 m_axis_tready,
   output logic [DATA_WIDTH-1:0]                m_axis_tdata,
   output logic                                 m_axis_tlast,
   output logic [SRC_ID_WIDTH-1:0]              m_axis_tid,
   input  logic [NUM_SOURCES-1:0]               src_enable,
   input  logic [CMS_ARB_BURST_LIMIT_WIDTH-1:0] burst_limit,
   output logic [SRC_ID_WIDTH-1:0]              active_src,
   output logic                                 locked,
   output logic [31:0]                          switch_count
);

   localparam int GW = $clog2(NUM_SOURCES);
   localparam int BW = CMS_ARB_BURST_LIMIT_WIDTH;

   if (NUM_SOURCES < 2 || NUM_SOURCES > CMS_ARB_MAX_SOURCES) begin : g_bad_num_sources
      $error("cms_stream_arbiter: NUM_SOURCES must be in 2..%0d", CMS_ARB_MAX_SOURCES);
   end

   arb_state_t              state_q;
   logic [GW-1:0]           grant_q;   // granted source while locked, previous grant while idle
   logic [SRC_ID_WIDTH-1:0] active_src_q;
   logic [BW-1:0]           beat_cnt_q;
   logic [BW-1:0]           beat_cnt_d;
   logic [BW-1:0]           limit_q;
   logic [31:0]             switch_count_q;
   logic                    m_tvalid_q;
   logic                    m_tlast_q;
   logic [DATA_WIDTH-1:0]   m_tdata_q;
   logic [SRC_ID_WIDTH-1:0] m_tid_q;

   logic                    pick_found;
   logic [GW-1:0]           pick_index;
   logic                    out_free;
   logic                    accept;
   logic                    release_grant;

   round_robin_picker #(.N(NUM_SOURCES)) u_picker (
      .request (s_axis_tvalid & src_enable),
      .last    (grant_q),
      .found   (pick_found),
      .index   (pick_index)
   );

   // The output register can take a beat when empty or being drained this cycle.
   assign out_free      = ~m_tvalid_q | m_axis_tready;
   assign accept        = (state_q == ARB_LOCKED) & s_axis_tvalid[grant_q] & out_free;
   assign beat_cnt_d    = beat_cnt_q + BW'(1);
   assign release_grant = s_axis_tlast[grant_q] | ((limit_q != '0) & (beat_cnt_d == limit_q));

   always_comb begin
      s_axis_tready = '0;
      if (state_q == ARB_LOCKED) s_axis_tready[grant_q] = out_free;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ARB_IDLE;
         grant_q        <= GW'(NUM_SOURCES - 1);
         active_src_q   <= '0;
         beat_cnt_q     <= '0;
         limit_q        <= '0;
         switch_count_q <= '0;
         m_tvalid_q     <= 1'b0;
         m_tlast_q      <= 1'b0;
         // NOTE: the output data register is reset too, so a beat caught mid-flight is dropped rather than replayed.
         m_tdata_q      <= '0;
         m_tid_q        <= '0;
      end else begin
         if (state_q == ARB_IDLE) begin
            if (pick_found) begin
               state_q        <= ARB_LOCKED;
               grant_q        <= pick_index;
               active_src_q   <= SRC_ID_WIDTH'(pick_index);
               beat_cnt_q     <= '0;
               limit_q        <= burst_limit;
               switch_count_q <= switch_count_q + 32'd1;
            end
         end else if (accept) begin
            beat_cnt_q <= beat_cnt_d;
            if (release_grant) state_q <= ARB_IDLE;
         end

         if (accept) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= s_axis_tdata[grant_q];
            m_tlast_q  <= s_axis_tlast[grant_q];
            m_tid_q    <= SRC_ID_WIDTH'(grant_q);
         end else if (m_axis_tready) begin
            m_tvalid_q <= 1'b0;
         end
      end
   end

   assign m_axis_tvalid = m_tvalid_q;
   assign m_axis_tdata  = m_tdata_q;
   assign m_axis_tlast  = m_tlast_q;
   assign m_axis_tid    = m_tid_q;
   assign active_src    = active_src_q;
   assign locked        = (state_q == ARB_LOCKED);
   assign switch_count  = switch_count_q;

endmodule

// File: tb/tb_cms_stream_arbiter.sv
// Self-checking bench for cms_stream_arbiter: queue-based source model and a
// packet-rotation reference model that predicts the merged beat order.
module tb_cms_stream_arbiter;

   localparam int NS = 2;
   localparam int DW = 32;
   localparam int SW = $clog2(NS);

   typedef logic [DW:0] beat_t;   // {last, data}
   typedef logic [SW:0] tl_t;     // {valid, tid}
   typedef struct packed {
      logic [SW-1:0] tid;
      logic          last;
      logic [DW-1:0] data;
   } out_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NS-1:0] s_axis_tvalid;
   logic [NS-1:0] s_axis_tready;
   logic [DW-1:0] s_axis_tdata [NS];
   logic [NS-1:0] s_axis_tlast;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tlast;
   logic [SW-1:0] m_axis_tid;
   logic [NS-1:0] src_enable;
   logic [15:0]   burst_limit;
   logic [SW-1:0] active_src;
   logic          locked;
   logic [31:0]   switch_count;

   cms_stream_arbiter #(.NUM_SOURCES(NS), .DATA_WIDTH(DW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tid    (m_axis_tid),
      .src_enable    (src_enable),
      .burst_limit   (burst_limit),
      .active_src    (active_src),
      .locked        (locked),
      .switch_count  (switch_count)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   beat_t src_q [NS][$];
   beat_t mq    [NS][$];
   bit    gate  [NS];
   out_t  obs[$];
   out_t  exp_q[$];
   tl_t   tl[$];
   tl_t   exp_tl[$];
   int    exp_grants;
   int    rdy_mode;   // 0: always ready, 1: random, 2: pattern 1,0,0,1
   int    cyc_count;
   int    vectors = 0;
   int    miscompares = 0;

   task automatic drive();
      for (int i = 0; i < NS; i++) begin
         if (gate[i] && src_q[i].size() > 0) begin
            s_axis_tvalid[i] = 1'b1;
            s_axis_tdata[i]  = src_q[i][0][DW-1:0];
            s_axis_tlast[i]  = src_q[i][0][DW];
         end else begin
            s_axis_tvalid[i] = 1'b0;
            s_axis_tdata[i]  = $urandom;
            s_axis_tlast[i]  = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic clear_sources();
      for (int i = 0; i < NS; i++) src_q[i].delete();
   endtask

   task automatic add_packet(input int s, input int len);
      for (int k = 1; k <= len; k++) src_q[s].push_back({(k == len), DW'($urandom)});
   endtask

   // Reset, apply settings and release reset away from the clock edge.
   task automatic start(input int mode, input logic [15:0] lim, input logic [NS-1:0] en);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rdy_mode      = mode;
      burst_limit   = lim;
      src_enable    = en;
      cyc_count     = 0;
      m_axis_tready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      obs.delete();
      tl.delete();
      for (int i = 0; i < NS; i++) gate[i] = 1'b1;
      drive();
      rst_n = 1'b1;
   endtask

   // One clock: sample handshakes mid-cycle, retire accepted beats after the edge.
   task automatic tick();
      logic [NS-1:0] acc;
      logic          mhs;
      logic          stalled;
      out_t          held;
      @(negedge clk);
      acc     = s_axis_tvalid & s_axis_tready;
      mhs     = m_axis_tvalid & m_axis_tready;
      stalled = m_axis_tvalid & ~m_axis_tready;
      held    = {m_axis_tid, m_axis_tlast, m_axis_tdata};
      vectors++;
      if ($countones(s_axis_tready) > 1 || (s_axis_tready !== '0 && locked !== 1'b1)) begin
         miscompares++;
         $display("FAIL ready_onehot: s_axis_tready=%b locked=%b", s_axis_tready, locked);
      end
      @(posedge clk); #1;
      for (int i = 0; i < NS; i++) if (acc[i]) void'(src_q[i].pop_front());
      if (mhs) obs.push_back(held);
      tl.push_back({m_axis_tvalid, (m_axis_tvalid ? m_axis_tid : SW'(0))});
      if (stalled) begin
         vectors++;
         if ({m_axis_tvalid, m_axis_tid, m_axis_tlast, m_axis_tdata} !== {1'b1, held}) begin
            miscompares++;
            $display("FAIL stall_hold: got %h, expected %h",
                     {m_axis_tvalid, m_axis_tid, m_axis_tlast, m_axis_tdata}, {1'b1, held});
         end
      end
      cyc_count++;
      case (rdy_mode)
         1:       m_axis_tready = 1'($urandom_range(0, 1));
         2:       m_axis_tready = (cyc_count % 4 == 0) || (cyc_count % 4 == 3);
         default: m_axis_tready = 1'b1;
      endcase
      drive();
   endtask

   task automatic run_until(input int nbeats, input int budget, input string name);
      int c = 0;
      while (obs.size() < nbeats && c < budget) begin
         tick();
         c++;
      end
      vectors++;
      if (obs.size() < nbeats) begin
         miscompares++;
         $display("FAIL %s_timeout: %0d beats seen, %0d required", name, obs.size(), nbeats);
      end
   endtask

   // Reference: rotate over sources holding data, one packet (or limit-sized chunk) per grant.
   task automatic run_model(input logic [15:0] lim, input logic [NS-1:0] en);
      int    cur;
      int    pick;
      int    n;
      beat_t b;
      exp_q.delete();
      exp_tl.delete();
      exp_grants = 0;
      for (int i = 0; i < NS; i++) mq[i] = src_q[i];
      cur = NS - 1;
      forever begin
         pick = -1;
         for (int k = 1; k <= NS; k++) begin
            int j = (cur + k) % NS;
            if (pick < 0 && en[j] && mq[j].size() > 0) pick = j;
         end
         if (pick < 0) break;
         exp_grants++;
         exp_tl.push_back('0);
         n = 0;
         while (mq[pick].size() > 0) begin
            b = mq[pick].pop_front();
            exp_q.push_back({SW'(pick), b[DW], b[DW-1:0]});
            exp_tl.push_back({1'b1, SW'(pick)});
            n++;
            if (b[DW] || (lim != 0 && n == int'(lim))) break;
         end
         cur = pick;
      end
   endtask

   task automatic test_reset();
      #2;
      vectors++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tid, s_axis_tready, locked, active_src} !== '0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b, expected 0",
                  {m_axis_tvalid, m_axis_tlast, m_axis_tid, s_axis_tready, locked, active_src});
      end
      vectors++;
      if (m_axis_tdata !== '0 || switch_count !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_data: tdata=%h switch_count=%0d, expected 0", m_axis_tdata, switch_count);
      end
      clear_sources();
      start(0, 16'd0, '1);
      repeat (3) tick();
      vectors++;
      if (locked !== 1'b0 || switch_count !== 32'd0 || m_axis_tvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_no_request: locked=%b switch_count=%0d tvalid=%b, expected 0",
                  locked, switch_count, m_axis_tvalid);
      end
   endtask

   task automatic test_round_robin();
      clear_sources();
      for (int p = 0; p < 3; p++) begin
         add_packet(0, 4);
         add_packet(1, 4);
      end
      run_model(16'd0, '1);
      start(0, 16'd0, '1);
      run_until(exp_q.size(), 200, "rr");
      repeat (4) tick();
      vectors++;
      if (tl.size() < exp_tl.size()) begin
         miscompares++;
         $display("FAIL rr_timeline_len: got %0d, expected >= %0d", tl.size(), exp_tl.size());
      end
      for (int i = 0; i < exp_tl.size() && i < tl.size(); i++) begin
         vectors++;
         if (tl[i] !== exp_tl[i]) begin
            miscompares++;
            $display("FAIL rr_cycle%0d: got {valid,tid}=%b, expected %b", i, tl[i], exp_tl[i]);
         end
      end
      vectors++;
      if (switch_count !== 32'(exp_grants)) begin
         miscompares++;
         $display("FAIL rr_switch_count: got %0d, expected %0d", switch_count, exp_grants);
      end
   endtask

   task automatic test_burst_limit();
      int c = 0;
      clear_sources();
      add_packet(0, 10);
      run_model(16'd3, '1);
      start(0, 16'd3, '1);
      // A limit change inside the first burst must not shorten it.
      while (obs.size() < exp_q.size() && c < 100) begin
         tick();
         c++;
         if (c == 2) burst_limit = 16'd2;
         if (c == 3) burst_limit = 16'd3;
      end
      repeat (3) tick();
      vectors++;
      if (obs.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL burst_count: got %0d beats, expected %0d", obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         vectors++;
         if (obs[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL burst_beat%0d: got %h, expected %h", i, obs[i], exp_q[i]);
         end
      end
      for (int i = 0; i < exp_tl.size() && i < tl.size(); i++) begin
         vectors++;
         if (tl[i] !== exp_tl[i]) begin
            miscompares++;
            $display("FAIL burst_cycle%0d: got {valid,tid}=%b, expected %b", i, tl[i], exp_tl[i]);
         end
      end
      vectors++;
      if (switch_count !== 32'd4 || active_src !== SW'(0)) begin
         miscompares++;
         $display("FAIL burst_grants: switch_count=%0d active_src=%0d, expected 4 and 0",
                  switch_count, active_src);
      end
   endtask

   task automatic test_backpressure();
      int total = 0;
      logic [15:0] lim;
      clear_sources();
      while (total < 64) begin
         int len = $urandom_range(1, 6);
         if (len > 64 - total) len = 64 - total;
         add_packet($urandom_range(0, NS - 1), len);
         total += len;
      end
      lim = 16'($urandom_range(0, 4));
      run_model(lim, '1);
      start(2, lim, '1);
      run_until(64, 2000, "bp");
      repeat (6) tick();
      vectors++;
      if (obs.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL bp_count: got %0d beats, expected %0d", obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         vectors++;
         if (obs[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL bp_beat%0d: got %h, expected %h", i, obs[i], exp_q[i]);
         end
      end
      vectors++;
      if (switch_count !== 32'(exp_grants)) begin
         miscompares++;
         $display("FAIL bp_switch_count: got %0d, expected %0d", switch_count, exp_grants);
      end
   endtask

   task automatic test_enable_mask();
      clear_sources();
      add_packet(0, 3);
      add_packet(0, 3);
      add_packet(1, 2);
      add_packet(1, 2);
      run_model(16'd0, 2'b10);
      start(0, 16'd0, 2'b10);
      run_until(exp_q.size(), 100, "en");
      repeat (6) tick();
      vectors++;
      if (obs.size() !== exp_q.size() || locked !== 1'b0) begin
         miscompares++;
         $display("FAIL en_mask: got %0d beats locked=%b, expected %0d beats locked=0",
                  obs.size(), locked, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         vectors++;
         if (obs[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL en_beat%0d: got %h, expected %h", i, obs[i], exp_q[i]);
         end
      end

      // Disabling the granted source mid-packet lets that packet finish, then nothing more.
      clear_sources();
      add_packet(1, 8);
      add_packet(1, 2);
      add_packet(0, 3);
      run_model(16'd0, 2'b10);
      start(0, 16'd0, 2'b10);
      run_until(2, 50, "en_mid");
      src_enable = 2'b00;
      repeat (30) tick();
      vectors++;
      if (obs.size() !== 8 || switch_count !== 32'd1 || locked !== 1'b0) begin
         miscompares++;
         $display("FAIL en_mid_packet: got %0d beats, %0d grants, locked=%b; expected 8, 1, 0",
                  obs.size(), switch_count, locked);
      end
      for (int i = 0; i < 8 && i < obs.size(); i++) begin
         vectors++;
         if (obs[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL en_mid_beat%0d: got %h, expected %h", i, obs[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_valid_drop();
      clear_sources();
      add_packet(0, 5);
      add_packet(1, 3);
      run_model(16'd0, '1);
      start(0, 16'd0, '1);
      run_until(2, 50, "drop");
      gate[0] = 1'b0;
      drive();
      repeat (8) tick();
      vectors++;
      if (locked !== 1'b1 || active_src !== SW'(0) || switch_count !== 32'd1) begin
         miscompares++;
         $display("FAIL drop_hold: locked=%b active_src=%0d grants=%0d, expected 1, 0, 1",
                  locked, active_src, switch_count);
      end
      gate[0] = 1'b1;
      drive();
      run_until(exp_q.size(), 100, "drop");
      repeat (4) tick();
      vectors++;
      if (obs.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL drop_count: got %0d beats, expected %0d", obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         vectors++;
         if (obs[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL drop_beat%0d: got %h, expected %h", i, obs[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      clear_sources();
      add_packet(0, 6);
      add_packet(1, 3);
      start(0, 16'd0, '1);
      run_until(1, 50, "rst_mid");
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tid, s_axis_tready, locked, active_src} !== '0 ||
          m_axis_tdata !== '0 || switch_count !== 32'd0) begin
         miscompares++;
         $display("FAIL rst_mid_async: tvalid=%b tdata=%h tready=%b locked=%b count=%0d, expected 0",
                  m_axis_tvalid, m_axis_tdata, s_axis_tready, locked, switch_count);
      end
      @(posedge clk); #1;
      obs.delete();
      tl.delete();
      run_model(16'd0, '1);
      rst_n = 1'b1;
      drive();
      run_until(exp_q.size(), 100, "rst_mid");
      repeat (4) tick();
      vectors++;
      if (obs.size() !== exp_q.size() || switch_count !== 32'(exp_grants)) begin
         miscompares++;
         $display("FAIL rst_mid_count: got %0d beats %0d grants, expected %0d and %0d",
                  obs.size(), switch_count, exp_q.size(), exp_grants);
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         vectors++;
         if (obs[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL rst_mid_beat%0d: got %h, expected %h", i, obs[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0]   lim;
      logic [NS-1:0] en;
      for (int it = 0; it < 6; it++) begin
         clear_sources();
         for (int p = 0; p < 3; p++)
            for (int s = 0; s < NS; s++) add_packet(s, $urandom_range(1, 5));
         lim = 16'($urandom_range(0, 3));
         en  = NS'($urandom_range(1, (1 << NS) - 1));
         run_model(lim, en);
         start(1, lim, en);
         run_until(exp_q.size(), 400, "rand");
         repeat (8) tick();
         vectors++;
         if (obs.size() !== exp_q.size() || switch_count !== 32'(exp_grants)) begin
            miscompares++;
            $display("FAIL rand%0d_count: got %0d beats %0d grants, expected %0d and %0d",
                     it, obs.size(), switch_count, exp_q.size(), exp_grants);
         end
         for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL rand%0d_beat%0d: got %h, expected %h", it, i, obs[i], exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      s_axis_tvalid = '0;
      s_axis_tlast  = '0;
      for (int i = 0; i < NS; i++) s_axis_tdata[i] = '0;
      m_axis_tready = 1'b1;
      src_enable    = '1;
      burst_limit   = '0;
      rdy_mode      = 0;
      cyc_count     = 0;

      test_reset();
      test_round_robin();
      test_burst_limit();
      test_backpressure();
      test_enable_mask();
      test_valid_drop();
      test_reset_mid_burst();
      test_random();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
